g711_codec_pipe: RTL and testbench
==================================

Name: g711_codec_pipe

Overview:
Pipelined, streaming G.711 companding codec. Per sample it selects A-law or mu-law, encodes a sign-magnitude PCM sample to an 8-bit codeword, decodes it back, and reports the absolute quantisation error. A channel tag travels with each sample so that TDM speech streams can share one instance.
The block sits between the PCM front end and the codeword/reconstruction consumers, with valid/ready flow control on both sides.

Parameters:
WIDTH, 14, PCM width in sign-magnitude: bit WIDTH-1 is the sign, the rest is magnitude; must be >= 14.
CH_W, 3, channel tag width.
CNT_W, 16, width of the saturating clip counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample this cycle
x_in  in  WIDTH  PCM sample, sign-magnitude (not two's complement)
mode  in  1  0 = A-law, 1 = mu-law; sampled together with x_in
ch_in  in  CH_W  channel tag
out_valid  out  1  output bundle valid
out_ready  in  1  downstream accepts the bundle
enc  out  8  codeword {sign, seg[2:0], mant[3:0]}
dec  out  WIDTH  reconstructed sample, sign-magnitude
err  out  WIDTH+1  |dec - x| computed as signed values, unsigned result
clip  out  1  input magnitude exceeded the mode limit
ch_out  out  CH_W  channel tag of the output bundle
mode_out  out  1  mode of the output bundle
clip_cnt  out  CNT_W  saturating count of clipped samples
clip_clr  in  1  synchronous clear of clip_cnt

Behaviour:
- Reset: all pipeline valids are 0. enc, dec, err, clip_cnt, ch_out and mode_out are 0. clip is 0.
- Pipeline:
  - 3 register stages: S1 captures the sample and clips it; S2 encodes; S3 decodes and computes the error.
  - Latency is 3 cycles from acceptance to out_valid when there is no stall.
- Flow control:
  - advance = !out_valid | out_ready, and in_ready = advance.
  - When advance is 0, every stage holds and all outputs stay stable.
  - A sample is accepted on in_valid & in_ready.
  - Bubbles are propagated, not collapsed.
  - Throughput is 1 sample per cycle.
- Clipping, where m is the magnitude:
  - A-law limit is 4095; mu-law limit is 8158.
  - If m exceeds the limit, m is set to the limit and the sample's clip flag is set.
  - Sign is preserved.
- A-law encode:
  - m < 32: seg = 0, mant = m[4:1].
  - Otherwise, with p the position of the leading one: seg = p - 4 and mant = the 4 bits below p.
- A-law decode:
  - seg = 0: mag = 2*mant + 1.
  - seg >= 1: mag = (2*(16 + mant) + 1) << (seg - 1).
- mu-law encode:
  - b = m + 33, always < 8192.
  - p = leading-one position of b; seg = p - 5; mant = the 4 bits below p.
- mu-law decode: mag = ((2*mant + 33) << seg) - 33.
- dec sign equals the input sign. A magnitude of 0 with sign 1 is passed through as -0.
- err uses the clipped-free original input: |signed(dec) - signed(x_in)|.
- clip_cnt:
  - Increments by 1 when a bundle with clip = 1 is transferred (out_valid & out_ready).
  - Saturates at all-ones.
  - clip_clr has priority and sets the counter to 0 in the same cycle, including a simultaneous increment.
- mode changes are permitted on every sample; there is no drain requirement.
- Reset asserted mid-stream discards all in-flight samples immediately (asynchronous).

Optional Feature:
- Macro: G711_ITU_INV_EN.
- When defined, enc carries ITU line coding:
  - A-law codeword is XOR 0x55.
  - mu-law codeword is fully inverted (XOR 0xFF).
  - The decoder undoes the inversion internally, so dec and err are unchanged.
- When undefined, enc is the plain {sign, seg, mant} format.

Test Plan:
- A-law, x = +100 -> enc = 0x29, dec = +102, err = 2, clip = 0, latency 3 cycles. With G711_ITU_INV_EN, enc = 0x7C.
- A-law, x = -5000 -> clip = 1, enc = 0xFF, dec = -4032, err = 968, clip_cnt increments to 1.
- mu-law, x = +100 -> enc = 0x20, dec = +99, err = 1. mu-law, x = 0 -> enc = 0x00, dec = 0. With G711_ITU_INV_EN, x = +100 gives enc = 0xDF.
- mu-law, x = +8191 -> clip = 1, enc = 0x7F, dec = +8031, err = 160. Then clip_clr together with another clipped transfer -> clip_cnt = 0.
- Stream of 8 samples on alternating modes and channels 0..7 with out_ready low for 4 cycles mid-stream:
  - in_ready drops during the stall and outputs hold.
  - No sample is lost or duplicated.
  - ch_out and mode_out match input order.
- Reset asserted with 3 samples in flight -> out_valid = 0 at once, all outputs 0, and the first sample after reset emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/g711_codec_pipe.sv
// g711_codec_pipe: three-stage streaming G.711 codec (A-law / mu-law).
//   S1 captures the sign-magnitude sample and clips it to the mode limit.
//   S2 encodes the clipped magnitude to {sign, seg, mant}.
//   S3 decodes the codeword and forms |dec - x| against the unclipped input.
// Handshake: a stage-wide advance = !out_valid | out_ready moves every
// stage at once (bubbles included); in_ready = advance, and a transfer
// happens on valid & ready at each side.
// Optional build macro G711_ITU_INV_EN: enc carries ITU line coding
// (A-law XOR 0x55, mu-law XOR 0xFF); the decoder strips it internally.
module g711_codec_pipe #(
    parameter int WIDTH = 14,
    parameter int CH_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic             mode,
    input  logic [CH_W-1:0]  ch_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       enc,
    output logic [WIDTH-1:0] dec,
    output logic [WIDTH:0]   err,
    output logic             clip,
    output logic [CH_W-1:0]  ch_out,
    output logic             mode_out,
    output logic [CNT_W-1:0] clip_cnt,
    input  logic             clip_clr
);

    // Magnitude width of the PCM word; after clipping 13 bits always suffice.
    localparam int MW = WIDTH - 1;

    localparam logic [12:0] A_LIM  = 13'd4095;
    localparam logic [12:0] MU_LIM = 13'd8158;

`ifdef G711_ITU_INV_EN
    localparam logic [7:0] A_INV  = 8'h55;
    localparam logic [7:0] MU_INV = 8'hFF;
`else
    localparam logic [7:0] A_INV  = 8'h00;
    localparam logic [7:0] MU_INV = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_adv;

    // ------------------------------------------------------------------
    // Stage 1: capture and clip
    // ------------------------------------------------------------------
    logic [MW-1:0] w_in_mag;
    logic [12:0]   w_in_lim;
    logic          w_in_clip;
    logic [12:0]   w_in_cmag;

    logic          r1_valid;
    logic          r1_sign;
    logic          r1_mode;
    logic [CH_W-1:0] r1_ch;
    logic          r1_clip;
    logic [12:0]   r1_cmag;
    logic [MW-1:0] r1_omag;

    assign w_in_mag  = x_in[WIDTH-2:0];
    assign w_in_lim  = mode ? MU_LIM : A_LIM;
    assign w_in_clip = (w_in_mag > MW'(w_in_lim));
    assign w_in_cmag = w_in_clip ? w_in_lim : w_in_mag[12:0];

    // S1 register: sample, clipped magnitude and sideband tags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_mode  <= 1'b0;
            r1_ch    <= '0;
            r1_clip  <= 1'b0;
            r1_cmag  <= '0;
            r1_omag  <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign  <= x_in[WIDTH-1];
            r1_mode  <= mode;
            r1_ch    <= ch_in;
            r1_clip  <= w_in_clip;
            r1_cmag  <= w_in_cmag;
            r1_omag  <= w_in_mag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: encode
    // ------------------------------------------------------------------
    logic [2:0]  w_a_seg;
    logic [3:0]  w_a_mant;
    logic [11:0] w_mu_bh;   // (m + 33) >> 1; the LSB of m + 33 never reaches the codeword
    logic [2:0]  w_mu_seg;
    logic [3:0]  w_mu_mant;
    logic [7:0]  w_code;

    // A-law segment search: highest set bit in 5..11 picks the segment
    always_comb begin
        w_a_seg  = 3'd0;
        w_a_mant = r1_cmag[4:1];
        for (int i = 5; i < 12; i++) begin
            if (r1_cmag[i]) begin
                w_a_seg  = 3'(i - 4);
                w_a_mant = r1_cmag[i-1 -: 4];
            end
        end
    end

    assign w_mu_bh = 12'((r1_cmag + 13'd33) >> 1);

    // mu-law segment search on the biased magnitude; bit 4 of bh is the floor
    always_comb begin
        w_mu_seg  = 3'd0;
        w_mu_mant = w_mu_bh[3:0];
        for (int j = 5; j < 12; j++) begin
            if (w_mu_bh[j]) begin
                w_mu_seg  = 3'(j - 4);
                w_mu_mant = w_mu_bh[j-1 -: 4];
            end
        end
    end

    assign w_code = r1_mode ? ({r1_sign, w_mu_seg, w_mu_mant} ^ MU_INV)
                            : ({r1_sign, w_a_seg,  w_a_mant}  ^ A_INV);

    logic            r2_valid;
    logic [7:0]      r2_code;
    logic            r2_mode;
    logic [CH_W-1:0] r2_ch;
    logic            r2_clip;
    logic [MW-1:0]   r2_omag;

    // S2 register: line codeword plus the original magnitude for the error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid <= 1'b0;
            r2_code  <= '0;
            r2_mode  <= 1'b0;
            r2_ch    <= '0;
            r2_clip  <= 1'b0;
            r2_omag  <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_code  <= w_code;
            r2_mode  <= r1_mode;
            r2_ch    <= r1_ch;
            r2_clip  <= r1_clip;
            r2_omag  <= r1_omag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: decode and error
    // ------------------------------------------------------------------
    logic [7:0]    w_plain;
    logic [2:0]    w_d_seg;
    logic [3:0]    w_d_mant;
    logic [12:0]   w_core;
    logic [12:0]   w_dmag13;
    logic [MW-1:0] w_dmag;
    logic [MW-1:0] w_diff;

    assign w_plain  = r2_code ^ (r2_mode ? MU_INV : A_INV);
    assign w_d_seg  = w_plain[6:4];
    assign w_d_mant = w_plain[3:0];
    // {1, mant, 1} is both 2*(16+mant)+1 for A-law and 2*mant+33 for mu-law
    assign w_core   = {7'd0, 1'b1, w_d_mant, 1'b1};

    // Segment expansion back to a linear magnitude
    always_comb begin
        w_dmag13 = '0;
        if (r2_mode) begin
            w_dmag13 = (w_core << w_d_seg) - 13'd33;
        end else if (w_d_seg == 3'd0) begin
            w_dmag13 = {8'd0, w_d_mant, 1'b1};
        end else begin
            w_dmag13 = w_core << (w_d_seg - 3'd1);
        end
    end

    assign w_dmag = MW'(w_dmag13);

    // dec always carries the input sign, so the signed difference reduces
    // to the distance between the two magnitudes
    assign w_diff = (w_dmag >= r2_omag) ? (w_dmag - r2_omag) : (r2_omag - w_dmag);

    logic             r3_valid;
    logic [7:0]       r3_enc;
    logic [WIDTH-1:0] r3_dec;
    logic [WIDTH:0]   r3_err;
    logic             r3_clip;
    logic [CH_W-1:0]  r3_ch;
    logic             r3_mode;

    // S3 register: the output bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r3_valid <= 1'b0;
            r3_enc   <= '0;
            r3_dec   <= '0;
            r3_err   <= '0;
            r3_clip  <= 1'b0;
            r3_ch    <= '0;
            r3_mode  <= 1'b0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r3_enc   <= r2_code;
            r3_dec   <= {w_plain[7], w_dmag};
            r3_err   <= (WIDTH+1)'(w_diff);
            r3_clip  <= r2_clip;
            r3_ch    <= r2_ch;
            r3_mode  <= r2_mode;
        end
    end

    // ------------------------------------------------------------------
    // Clip counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_clip_cnt;

    // Saturating count of clipped bundles; clear wins over an increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_cnt <= '0;
        end else if (clip_clr) begin
            r_clip_cnt <= '0;
        end else if (r3_valid && out_ready && r3_clip && (r_clip_cnt != '1)) begin
            r_clip_cnt <= r_clip_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_adv     = !r3_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r3_valid;
    assign enc       = r3_enc;
    assign dec       = r3_dec;
    assign err       = r3_err;
    assign clip      = r3_clip;
    assign ch_out    = r3_ch;
    assign mode_out  = r3_mode;
    assign clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_g711_codec_pipe.sv
// tb_g711_codec_pipe: directed and randomized checks of g711_codec_pipe
// against an arithmetic G.711 reference model with an expected queue.
module tb_g711_codec_pipe;

    localparam int W     = 14;
    localparam int CH_W  = 3;
    localparam int CNT_W = 16;

`ifdef G711_ITU_INV_EN
    localparam logic [7:0] B_A_INV  = 8'h55;
    localparam logic [7:0] B_MU_INV = 8'hFF;
`else
    localparam logic [7:0] B_A_INV  = 8'h00;
    localparam logic [7:0] B_MU_INV = 8'h00;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, mode, out_valid, out_ready;
    logic [W-1:0]    x_in, dec;
    logic [CH_W-1:0] ch_in, ch_out;
    logic [7:0]      enc;
    logic [W:0]      err;
    logic            clip, mode_out, clip_clr;
    logic [CNT_W-1:0] clip_cnt;

    g711_codec_pipe #(.WIDTH(W), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .mode(mode), .ch_in(ch_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .enc(enc), .dec(dec), .err(err), .clip(clip),
        .ch_out(ch_out), .mode_out(mode_out),
        .clip_cnt(clip_cnt), .clip_clr(clip_clr)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [7:0]      enc;
        logic [W-1:0]    dec;
        logic [W:0]      err;
        logic            clip;
        logic [CH_W-1:0] ch;
        logic            md;
        int              acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   cnt_model = 0;
    bit   lat_chk = 0;
    bit   held = 0;
    logic [7:0]      s_enc, last_enc;
    logic [W-1:0]    s_dec, last_dec;
    logic [W:0]      s_err, last_err;
    logic            s_clip, last_clip, s_md;
    logic [CH_W-1:0] s_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // G.711 reference: segment found by powers of two, values by plain arithmetic
    function automatic exp_t model(input logic [W-1:0] x, input logic md, input logic [CH_W-1:0] ch);
        exp_t e;
        int   m, om, seg, mant, p, b, dm, xv, dv, diff;
        bit   s;
        s  = x[W-1];
        om = int'(x[W-2:0]);
        m  = om;
        e.clip = 1'b0;
        if (!md && m > 4095) begin m = 4095; e.clip = 1'b1; end
        if (md && m > 8158)  begin m = 8158; e.clip = 1'b1; end
        if (!md) begin
            if (m < 32) begin
                seg  = 0;
                mant = m / 2;
                dm   = 2 * mant + 1;
            end else begin
                p = 0;
                while ((1 << (p + 1)) <= m) p++;
                seg  = p - 4;
                mant = (m / (1 << (p - 4))) % 16;
                dm   = (2 * (16 + mant) + 1) * (1 << (seg - 1));
            end
            e.enc = {s, 3'(seg), 4'(mant)} ^ B_A_INV;
        end else begin
            b = m + 33;
            p = 0;
            while ((1 << (p + 1)) <= b) p++;
            seg  = p - 5;
            mant = (b / (1 << (p - 4))) % 16;
            dm   = (2 * mant + 33) * (1 << seg) - 33;
            e.enc = {s, 3'(seg), 4'(mant)} ^ B_MU_INV;
        end
        xv   = s ? -om : om;
        dv   = s ? -dm : dm;
        diff = dv - xv;
        if (diff < 0) diff = -diff;
        e.dec = {s, (W-1)'(dm)};
        e.err = (W+1)'(diff);
        e.ch  = ch;
        e.md  = md;
        e.acc = cyc;
        return e;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic v, input logic [W-1:0] x, input logic md,
                         input logic [CH_W-1:0] ch, input logic rdy, input logic clr,
                         output bit acc);
        exp_t e;
        bit   xfer;
        bit   e_clip;
        in_valid = v; x_in = x; mode = md; ch_in = ch; out_ready = rdy; clip_clr = clr;
        @(negedge clk);
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_enc", 32'(enc), 32'(s_enc));
            chk("hold_dec", 32'(dec), 32'(s_dec));
            chk("hold_err", 32'(err), 32'(s_err));
            chk("hold_clip", 32'(clip), 32'(s_clip));
            chk("hold_ch", 32'(ch_out), 32'(s_ch));
            chk("hold_mode", 32'(mode_out), 32'(s_md));
        end
        chk("in_ready", 32'(in_ready), 32'(!out_valid || rdy));
        chk("clip_cnt", 32'(clip_cnt), 32'(cnt_model));
        xfer   = out_valid && rdy;
        e_clip = 1'b0;
        if (xfer) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_miss++;
                $error("FAIL unexpected_bundle observed=enc %0h expected=no bundle", enc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                e_clip = e.clip;
                chk("enc", 32'(enc), 32'(e.enc));
                chk("dec", 32'(dec), 32'(e.dec));
                chk("err", 32'(err), 32'(e.err));
                chk("clip", 32'(clip), 32'(e.clip));
                chk("ch_out", 32'(ch_out), 32'(e.ch));
                chk("mode_out", 32'(mode_out), 32'(e.md));
                if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd3);
                last_enc = enc; last_dec = dec; last_err = err; last_clip = clip;
            end
        end
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(x, md, ch));
        held = out_valid && !rdy;
        s_enc = enc; s_dec = dec; s_err = err; s_clip = clip; s_ch = ch_out; s_md = mode_out;
        @(posedge clk);
        cyc++;
        if (clr) cnt_model = 0;
        else if (xfer && e_clip && cnt_model < (1 << CNT_W) - 1) cnt_model++;
        #1;
    endtask

    task automatic drain();
        bit acc;
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 30) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
            k++;
        end
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_miss++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
        end
    endtask

    task automatic send_one(input logic [W-1:0] x, input logic md, input logic [CH_W-1:0] ch);
        bit acc;
        int k;
        acc = 0;
        k = 0;
        while (!acc && k < 20) begin
            cycle(1'b1, x, md, ch, 1'b1, 1'b0, acc);
            k++;
        end
        n_vec++;
        assert (acc) else begin
            n_miss++;
            $error("FAIL accept_timeout observed=not accepted expected=accepted");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit               acc;
        int               idx;
        logic [W-1:0]     xs [8];
        logic [W-1:0]     rx;
        logic             rdy;

        reset = 1'b1; in_valid = 0; x_in = '0; mode = 0; ch_in = '0; out_ready = 0; clip_clr = 0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_enc", 32'(enc), 32'd0);
        chk("rst_dec", 32'(dec), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        chk("rst_ch", 32'(ch_out), 32'd0);
        chk("rst_mode", 32'(mode_out), 32'd0);
        chk("rst_cnt", 32'(clip_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed single samples, latency checked on each
        lat_chk = 1;
        send_one({1'b0, 13'd100}, 1'b0, 3'd1);
        drain();
        chk("a100_enc", 32'(last_enc), 32'(8'h29 ^ B_A_INV));
        chk("a100_dec", 32'(last_dec), 32'd102);
        chk("a100_err", 32'(last_err), 32'd2);
        chk("a100_clip", 32'(last_clip), 32'd0);

        send_one({1'b1, 13'd5000}, 1'b0, 3'd2);
        drain();
        chk("a5000_enc", 32'(last_enc), 32'(8'hFF ^ B_A_INV));
        chk("a5000_dec", 32'(last_dec), 32'(14'h2000 | 14'd4032));
        chk("a5000_err", 32'(last_err), 32'd968);
        chk("a5000_clip", 32'(last_clip), 32'd1);
        chk("a5000_cnt", 32'(clip_cnt), 32'd1);

        send_one({1'b0, 13'd100}, 1'b1, 3'd3);
        drain();
        chk("u100_enc", 32'(last_enc), 32'(8'h20 ^ B_MU_INV));
        chk("u100_dec", 32'(last_dec), 32'd99);
        chk("u100_err", 32'(last_err), 32'd1);

        send_one({1'b0, 13'd0}, 1'b1, 3'd4);
        drain();
        chk("u0_enc", 32'(last_enc), 32'(8'h00 ^ B_MU_INV));
        chk("u0_dec", 32'(last_dec), 32'd0);

        send_one({1'b0, 13'd8191}, 1'b1, 3'd5);
        drain();
        chk("u8191_enc", 32'(last_enc), 32'(8'h7F ^ B_MU_INV));
        chk("u8191_dec", 32'(last_dec), 32'd8031);
        chk("u8191_err", 32'(last_err), 32'd160);
        chk("u8191_cnt", 32'(clip_cnt), 32'd2);

        // clear together with a clipped transfer
        send_one({1'b0, 13'd8191}, 1'b1, 3'd6);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, acc);
        chk("clr_wins", 32'(clip_cnt), 32'd0);
        drain();

        // 8-sample stream, alternating modes, channels 0..7, 4-cycle stall
        lat_chk = 0;
        for (int i = 0; i < 8; i++) xs[i] = W'($urandom_range(0, (1 << W) - 1));
        idx = 0;
        for (int k = 0; k < 60; k++) begin
            if (idx >= 8 && exp_q.size() == 0) break;
            if (k == 5) chk("stall_in_ready", 32'(in_ready), 32'd0);
            rdy = !(k >= 4 && k < 8);
            cycle(idx < 8, xs[idx & 7], 1'(idx & 1), CH_W'(idx), rdy, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stream_all_sent", 32'(idx), 32'd8);
        drain();

        // randomized traffic with random back-pressure and occasional clears
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: rx = W'($urandom_range(0, 63));
                1: rx = W'($urandom_range(0, 4095));
                2: rx = W'($urandom_range(4000, 8191));
                default: rx = W'($urandom_range(0, (1 << (W - 1)) - 1));
            endcase
            rx[W-1] = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, rx, 1'($urandom_range(0, 1)),
                  CH_W'($urandom_range(0, (1 << CH_W) - 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, acc);
        end
        drain();

        // make sure the counter is non-zero before the reset test
        send_one({1'b1, 13'd6000}, 1'b0, 3'd7);
        drain();

        // reset with three samples in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b1, {1'b0, 13'd5000}, 1'b0, CH_W'(i + 1), 1'b0, 1'b0, acc);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_enc", 32'(enc), 32'd0);
        chk("mid_rst_dec", 32'(dec), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_clip", 32'(clip), 32'd0);
        chk("mid_rst_ch", 32'(ch_out), 32'd0);
        chk("mid_rst_mode", 32'(mode_out), 32'd0);
        chk("mid_rst_cnt", 32'(clip_cnt), 32'd0);
        exp_q.delete();
        cnt_model = 0;
        held = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        lat_chk = 1;
        send_one({1'b0, 13'd1234}, 1'b0, 3'd5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
